// File: rtl/posicionador_comida.sv
// Draws a free food cell (x,y) from random nibbles, retrying occupied cells; optional linear-scan fallback under VARREDURA_FALLBACK_EN.
// Latency pedido -> pronto is 5 cycles on a free first try; further nibbles stall on aleat_valido, pedido is ignored while ocupado.
module posicionador_comida #(
  parameter int LARGURA_GRADE  = 16,
  parameter int ALTURA_GRADE   = 16,
  parameter int MAX_TENTATIVAS = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       pedido,
  input  logic [3:0] aleatorio,
  input  logic       aleat_valido,
  output logic       consulta_en,
  output logic [3:0] consulta_x,
  output logic [3:0] consulta_y,
  input  logic       consulta_ocupada,
  output logic [3:0] comida_x,
  output logic [3:0] comida_y,
  output logic       pronto,
  output logic       falha,
  output logic       ocupado
);

  localparam logic [4:0] LIM_X    = 5'(LARGURA_GRADE);
  localparam logic [4:0] LIM_Y    = 5'(ALTURA_GRADE);
  localparam logic [7:0] LIM_TENT = 8'(MAX_TENTATIVAS);

  typedef enum logic [2:0] {
    OCIOSO,
    SORTEIA_X,
    SORTEIA_Y,
    CONSULTA,
    ESPERA
`ifdef VARREDURA_FALLBACK_EN
    ,
    VARREDURA,
    VARRE_ESPERA
`endif
  } estado_t;

  estado_t    estado_q, estado_d;
  logic [3:0] cand_x_q, cand_x_d;
  logic [3:0] cand_y_q, cand_y_d;
  logic [7:0] tent_q, tent_d;
  logic [3:0] comida_x_q, comida_x_d;
  logic [3:0] comida_y_q, comida_y_d;
  logic       pronto_q, pronto_d;
  logic       falha_q, falha_d;

`ifdef VARREDURA_FALLBACK_EN
  localparam logic [3:0] ULT_X   = 4'(LARGURA_GRADE - 1);
  localparam logic [3:0] ULT_Y   = 4'(ALTURA_GRADE - 1);
  localparam logic [8:0] ULT_CEL = 9'(LARGURA_GRADE * ALTURA_GRADE - 1);

  logic [8:0] varre_q, varre_d;
  logic [3:0] prox_x, prox_y;

  // Next cell in raster order, wrapping from the last cell back to (0,0).
  always_comb begin
    prox_x = cand_x_q + 4'd1;
    prox_y = cand_y_q;
    if (cand_x_q == ULT_X) begin
      prox_x = 4'd0;
      prox_y = (cand_y_q == ULT_Y) ? 4'd0 : cand_y_q + 4'd1;
    end
  end
`endif

  always_comb begin
    estado_d   = estado_q;
    cand_x_d   = cand_x_q;
    cand_y_d   = cand_y_q;
    tent_d     = tent_q;
    comida_x_d = comida_x_q;
    comida_y_d = comida_y_q;
    pronto_d   = 1'b0;
    falha_d    = 1'b0;
`ifdef VARREDURA_FALLBACK_EN
    varre_d    = varre_q;
`endif
    case (estado_q)
      OCIOSO: begin
        if (pedido) begin
          tent_d   = 8'd0;
          estado_d = SORTEIA_X;
        end
      end
      SORTEIA_X: begin
        if (aleat_valido && ({1'b0, aleatorio} < LIM_X)) begin
          cand_x_d = aleatorio;
          estado_d = SORTEIA_Y;
        end
      end
      SORTEIA_Y: begin
        if (aleat_valido && ({1'b0, aleatorio} < LIM_Y)) begin
          cand_y_d = aleatorio;
          estado_d = CONSULTA;
        end
      end
      CONSULTA: estado_d = ESPERA;
      ESPERA: begin
        if (!consulta_ocupada) begin
          comida_x_d = cand_x_q;
          comida_y_d = cand_y_q;
          pronto_d   = 1'b1;
          estado_d   = OCIOSO;
        end else begin
          tent_d = tent_q + 8'd1;
          if (tent_q + 8'd1 == LIM_TENT) begin
`ifdef VARREDURA_FALLBACK_EN
            cand_x_d = prox_x;
            cand_y_d = prox_y;
            varre_d  = 9'd0;
            estado_d = VARREDURA;
`else
            falha_d  = 1'b1;
            estado_d = OCIOSO;
`endif
          end else begin
            estado_d = SORTEIA_X;
          end
        end
      end
`ifdef VARREDURA_FALLBACK_EN
      VARREDURA: estado_d = VARRE_ESPERA;
      VARRE_ESPERA: begin
        if (!consulta_ocupada) begin
          comida_x_d = cand_x_q;
          comida_y_d = cand_y_q;
          pronto_d   = 1'b1;
          estado_d   = OCIOSO;
        end else if (varre_q == ULT_CEL) begin
          falha_d  = 1'b1;
          estado_d = OCIOSO;
        end else begin
          varre_d  = varre_q + 9'd1;
          cand_x_d = prox_x;
          cand_y_d = prox_y;
          estado_d = VARREDURA;
        end
      end
`endif
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q   <= OCIOSO;
      cand_x_q   <= 4'd0;
      cand_y_q   <= 4'd0;
      tent_q     <= 8'd0;
      comida_x_q <= 4'd0;
      comida_y_q <= 4'd0;
      pronto_q   <= 1'b0;
      falha_q    <= 1'b0;
`ifdef VARREDURA_FALLBACK_EN
      varre_q    <= 9'd0;
`endif
    end else begin
      estado_q   <= estado_d;
      cand_x_q   <= cand_x_d;
      cand_y_q   <= cand_y_d;
      tent_q     <= tent_d;
      comida_x_q <= comida_x_d;
      comida_y_q <= comida_y_d;
      pronto_q   <= pronto_d;
      falha_q    <= falha_d;
`ifdef VARREDURA_FALLBACK_EN
      varre_q    <= varre_d;
`endif
    end
  end

`ifdef VARREDURA_FALLBACK_EN
  assign consulta_en = (estado_q == CONSULTA) || (estado_q == VARREDURA);
`else
  assign consulta_en = (estado_q == CONSULTA);
`endif
  assign consulta_x = cand_x_q;
  assign consulta_y = cand_y_q;
  assign comida_x   = comida_x_q;
  assign comida_y   = comida_y_q;
  assign pronto     = pronto_q;
  assign falha      = falha_q;
  assign ocupado    = (estado_q != OCIOSO);

endmodule

// File: tb/tb_posicionador_comida.sv
// Bench for posicionador_comida on a 10x12 grid: directed cases plus randomized requests against a transaction-level model.
`timescale 1ns/1ps
module tb_posicionador_comida;
  localparam int W = 10;
  localparam int H = 12;
  localparam int M = 8;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       pedido = 1'b0;
  logic [3:0] aleatorio = 4'd0;
  logic       aleat_valido = 1'b0;
  logic       consulta_ocupada = 1'b0;
  logic       consulta_en;
  logic [3:0] consulta_x, consulta_y, comida_x, comida_y;
  logic       pronto, falha, ocupado;

  posicionador_comida #(.LARGURA_GRADE(W), .ALTURA_GRADE(H), .MAX_TENTATIVAS(M)) dut (
    .clock(clock), .reset_n(reset_n), .pedido(pedido), .aleatorio(aleatorio),
    .aleat_valido(aleat_valido), .consulta_en(consulta_en), .consulta_x(consulta_x),
    .consulta_y(consulta_y), .consulta_ocupada(consulta_ocupada), .comida_x(comida_x),
    .comida_y(comida_y), .pronto(pronto), .falha(falha), .ocupado(ocupado)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  bit occ [16][16];
  logic [3:0] nib_q [$];
  int pct = 100, spur_pct = 0, cyc = 0;
  int n_look, n_pronto, n_falha, look_cyc, pr_cyc, t0;
  logic [7:0] look_log [$];
  bit done;
  logic lk_pend = 1'b0;
  logic [3:0] lk_x = 4'd0, lk_y = 4'd0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one step per cycle from the inputs the DUT samples on the next edge.
  int ph = 0, mx = 0, my = 0, mtries = 0, mscan = 0, m_fx = 0, m_fy = 0, lin;
  bit e_en = 0, e_pr = 0, e_fa = 0, e_oc = 0;
  int e_cx = 0, e_cy = 0;

  always @(negedge clock) begin : modelo
    if (!reset_n) begin
      ph = 0; mx = 0; my = 0; mtries = 0; mscan = 0; m_fx = 0; m_fy = 0;
      e_en = 0; e_pr = 0; e_fa = 0; e_oc = 0; e_cx = 0; e_cy = 0;
      chk("rst_consulta_en", consulta_en, 0);
      chk("rst_pronto", pronto, 0);
      chk("rst_falha", falha, 0);
      chk("rst_ocupado", ocupado, 0);
      chk("rst_comida", {comida_x, comida_y}, 0);
      chk("rst_consulta_xy", {consulta_x, consulta_y}, 0);
    end else begin
      chk("consulta_en", consulta_en, e_en);
      if (e_en) begin
        chk("consulta_x", consulta_x, e_cx);
        chk("consulta_y", consulta_y, e_cy);
      end
      chk("pronto", pronto, e_pr);
      chk("falha", falha, e_fa);
      chk("ocupado", ocupado, e_oc);
      chk("comida_x", comida_x, m_fx);
      chk("comida_y", comida_y, m_fy);
      e_pr = 0; e_fa = 0;
      case (ph)
        0: if (pedido) begin ph = 1; mtries = 0; end
        1, 2: if (aleat_valido) begin
          if (nib_q.size() > 0) void'(nib_q.pop_front());
          if (ph == 1 && aleatorio < W) begin mx = aleatorio; ph = 2; end
          else if (ph == 2 && aleatorio < H) begin my = aleatorio; ph = 3; end
        end
        3: ph = 4;
        4: begin
          if (!consulta_ocupada) begin
            m_fx = mx; m_fy = my; e_pr = 1; ph = 0;
          end else begin
            mtries++;
            if (mtries == M) begin
`ifdef VARREDURA_FALLBACK_EN
              lin = (my * W + mx + 1) % (W * H);
              mx = lin % W; my = lin / W; mscan = 1; ph = 5;
`else
              e_fa = 1; ph = 0;
`endif
            end else ph = 1;
          end
        end
        5: ph = 6;
        6: begin
          if (!consulta_ocupada) begin
            m_fx = mx; m_fy = my; e_pr = 1; ph = 0;
          end else if (mscan == W * H) begin
            e_fa = 1; ph = 0;
          end else begin
            lin = (my * W + mx + 1) % (W * H);
            mx = lin % W; my = lin / W; mscan++; ph = 5;
          end
        end
        default: ph = 0;
      endcase
      e_en = (ph == 3) || (ph == 5);
      e_oc = (ph != 0);
      e_cx = mx; e_cy = my;
    end
  end

  // Observes the cycle, then drives the next cycle's inputs including the occupancy answer.
  task automatic tick();
    @(negedge clock);
    lk_pend = consulta_en; lk_x = consulta_x; lk_y = consulta_y;
    if (consulta_en) begin
      n_look++; look_log.push_back({consulta_x, consulta_y}); look_cyc = cyc + 1;
    end
    if (pronto) begin n_pronto++; pr_cyc = cyc + 1; end
    if (falha) n_falha++;
    if (pronto || falha) done = 1;
    @(posedge clock);
    cyc++;
    #1;
    pedido = ocupado && ($urandom_range(99) < spur_pct);
    consulta_ocupada = lk_pend ? occ[lk_x][lk_y] : 1'($urandom);
    aleat_valido = ($urandom_range(99) < pct);
    aleatorio = (nib_q.size() > 0) ? nib_q[0] : 4'($urandom);
  endtask

  task automatic load2(input logic [3:0] a, input logic [3:0] b);
    nib_q.push_back(a); nib_q.push_back(b);
    aleatorio = nib_q[0];
  endtask

  task automatic fill_occ(input int density);
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        occ[x][y] = ($urandom_range(99) < density);
  endtask

  task automatic request(input int budget);
    n_look = 0; n_pronto = 0; n_falha = 0; look_log.delete(); done = 0;
    pedido = 1; t0 = cyc + 1;
    for (int i = 0; i < budget && !done; i++) tick();
    if (!done) chk("timeout", 0, 1);
  endtask

  initial begin
    fill_occ(0);
    repeat (3) tick();
    reset_n = 1;
    tick();

    // Free first try: lookup at T+3, pronto at T+5.
    load2(4'd3, 4'd7);
    request(100);
    chk("t1_latency", pr_cyc - t0, 5);
    chk("t1_lookup_cycle", look_cyc - t0, 3);
    chk("t1_lookups", n_look, 1);
    chk("t1_lookup_xy", look_log[0], 8'h37);
    chk("t1_comida", {comida_x, comida_y}, 8'h37);

    // Out-of-range nibbles (12 for x, 13 for y) are discarded.
    load2(4'd12, 4'd4); load2(4'd13, 4'd9);
    request(100);
    chk("t2_lookups", n_look, 1);
    chk("t2_comida", {comida_x, comida_y}, 8'h49);

    // One occupied retry.
    occ[1][1] = 1;
    load2(4'd1, 4'd1); load2(4'd2, 4'd2);
    request(100);
    chk("t3_lookups", n_look, 2);
    chk("t3_pronto", n_pronto, 1);
    chk("t3_comida", {comida_x, comida_y}, 8'h22);

    // Everything occupied.
    fill_occ(100);
    request(3000);
    chk("t4_falha", n_falha, 1);
    chk("t4_pronto", n_pronto, 0);
`ifdef VARREDURA_FALLBACK_EN
    chk("t4_lookups", n_look, M + W * H);
`else
    chk("t4_lookups", n_look, M);
`endif
    chk("t4_comida_kept", {comida_x, comida_y}, 8'h22);

    // Only (0,0) free, every random candidate is the last cell.
    occ[0][0] = 0;
    for (int i = 0; i < M; i++) load2(4'(W - 1), 4'(H - 1));
    request(3000);
`ifdef VARREDURA_FALLBACK_EN
    chk("t5_lookups", n_look, M + 1);
    chk("t5_first_scan", look_log[M], 0);
    chk("t5_pronto", n_pronto, 1);
    chk("t5_comida", {comida_x, comida_y}, 0);
`else
    chk("t5_lookups", n_look, M);
    chk("t5_falha", n_falha, 1);
    chk("t5_comida", {comida_x, comida_y}, 8'h22);
`endif

    // Reset during the answer cycle.
    fill_occ(0);
    load2(4'd8, 4'd3);
    request(100);
    chk("t6_pre_comida", {comida_x, comida_y}, 8'h83);
    load2(4'd5, 4'd6);
    n_look = 0; n_pronto = 0; n_falha = 0; done = 0; pedido = 1;
    for (int i = 0; i < 50 && n_look == 0; i++) tick();
    chk("t6_lookup_seen", n_look, 1);
    #2 reset_n = 0;
    #1;
    chk("t6_rst_ocupado", ocupado, 0);
    chk("t6_rst_comida", {comida_x, comida_y}, 0);
    chk("t6_rst_pulses", {pronto, falha, consulta_en}, 0);
    nib_q.delete();
    repeat (2) tick();
    reset_n = 1;
    repeat (4) tick();
    chk("t6_no_stale", n_pronto + n_falha, 0);
    load2(4'd6, 4'd8);
    request(100);
    chk("t6_pronto", n_pronto, 1);
    chk("t6_comida", {comida_x, comida_y}, 8'h68);

    // Randomized requests.
    pct = 60; spur_pct = 20;
    for (int r = 0; r < 40; r++) begin
      case ($urandom_range(3))
        0: fill_occ(0);
        1: fill_occ(40);
        2: fill_occ(85);
        default: fill_occ(100);
      endcase
      if ($urandom_range(1) == 1) load2(4'($urandom), 4'($urandom));
      request(4000);
      chk("rnd_one_result", n_pronto + n_falha, 1);
      repeat ($urandom_range(3)) tick();
      nib_q.delete();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
